// File: rtl/seq_mul_if.sv
// rtl/seq_mul_if.sv - start/done handshake bundle for the sequential multiplier
interface seq_mul_if #(
  parameter int WIDTH = 4
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - shift-and-add multiplier, one product per WIDTH+2 cycles
// SEQ_MUL_SIGNED_EN selects two's-complement operands and product.
module seq_mul #(
  parameter int WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  seq_mul_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    product_q, product_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    acc_sum;
  logic [PW-1:0]    result;

  assign acc_sum = mplier_q[0] ? acc_q + mcand_q : acc_q;

`ifdef SEQ_MUL_SIGNED_EN
  logic sign_q, sign_d;

  // Most-negative input negates to itself, which is its correct unsigned magnitude.
  assign a_mag  = bus.a[WIDTH-1] ? WIDTH'(0) - bus.a : bus.a;
  assign b_mag  = bus.b[WIDTH-1] ? WIDTH'(0) - bus.b : bus.b;
  assign result = sign_q ? PW'(0) - acc_sum : acc_sum;
`else
  assign a_mag  = bus.a;
  assign b_mag  = bus.b;
  assign result = acc_sum;
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
    sign_d    = sign_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          count_d  = COUNT_INIT;
          busy_d   = 1'b1;
          state_d  = S_RUN;
`ifdef SEQ_MUL_SIGNED_EN
          sign_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`endif
        end
      end
      S_RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - COUNT_ONE;
        if (count_q == COUNT_ONE) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          product_d = result;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SEQ_MUL_SIGNED_EN
      sign_q    <= sign_d;
`endif
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_seq_mul.sv
// tb/tb_seq_mul.sv - randomized and directed checks of seq_mul at WIDTH 2, 4 and 8
module tb_seq_mul;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_mul_if #(.WIDTH(2)) if2 ();
  seq_mul_if #(.WIDTH(4)) if4 ();
  seq_mul_if #(.WIDTH(8)) if8 ();

  seq_mul #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  seq_mul #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  seq_mul #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference product: plain integer multiply of the operands as the spec interprets them.
  function automatic logic [63:0] model(input int w, input logic [63:0] a, input logic [63:0] b);
    longint sa, sb;
    logic [63:0] mask;
    mask = (64'd1 << (2 * w)) - 64'd1;
    sa = longint'(a & ((64'd1 << w) - 64'd1));
    sb = longint'(b & ((64'd1 << w) - 64'd1));
`ifdef SEQ_MUL_SIGNED_EN
    if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
    if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
`endif
    return 64'(sa * sb) & mask;
  endfunction

  task automatic set_in(input int w, input logic s, input logic [63:0] a, input logic [63:0] b);
    case (w)
      2: begin if2.start = s; if2.a = a[1:0]; if2.b = b[1:0]; end
      4: begin if4.start = s; if4.a = a[3:0]; if4.b = b[3:0]; end
      default: begin if8.start = s; if8.a = a[7:0]; if8.b = b[7:0]; end
    endcase
  endtask

  function automatic logic [63:0] busy_of(input int w);
    case (w)
      2: return 64'(if2.busy);
      4: return 64'(if4.busy);
      default: return 64'(if8.busy);
    endcase
  endfunction

  function automatic logic [63:0] done_of(input int w);
    case (w)
      2: return 64'(if2.done);
      4: return 64'(if4.done);
      default: return 64'(if8.done);
    endcase
  endfunction

  function automatic logic [63:0] prod_of(input int w);
    case (w)
      2: return 64'(if2.product);
      4: return 64'(if4.product);
      default: return 64'(if8.product);
    endcase
  endfunction

  // One full operation; operands are scrambled during RUN to show they were captured.
  task automatic do_op(input int w, input logic [63:0] a, input logic [63:0] b, input string tag);
    int lat;
    logic [63:0] exp;
    exp = model(w, a, b);
    @(negedge clk);
    set_in(w, 1'b1, a, b);
    @(posedge clk);
    @(negedge clk);
    set_in(w, 1'b0, ~a, ~b);
    check({tag, "_busy"}, busy_of(w), 64'd1);
    lat = 0;
    for (int n = 1; n <= w + 4; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_of(w) == 64'd1) begin
        lat = n;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(w));
    check({tag, "_product"}, prod_of(w), exp);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_width"}, done_of(w), 64'd0);
    check({tag, "_idle"}, busy_of(w), 64'd0);
    check({tag, "_hold"}, prod_of(w), exp);
  endtask

  logic [63:0] ra, rb;
  logic [63:0] ha [3];
  logic [63:0] hb [3];
  int pulses, last, dn;

  initial begin
    rst = 1'b0;
    set_in(2, 1'b0, 64'd0, 64'd0);
    set_in(4, 1'b0, 64'd0, 64'd0);
    set_in(8, 1'b0, 64'd0, 64'd0);
    #1 rst = 1'b1;
    #2;
    check("rst_busy2", 64'(if2.busy), 64'd0);
    check("rst_done4", 64'(if4.done), 64'd0);
    check("rst_prod4", 64'(if4.product), 64'd0);
    check("rst_busy8", 64'(if8.busy), 64'd0);
    check("rst_prod8", 64'(if8.product), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      do_op(2, 64'(i >> 2), 64'(i & 3), "w2_sweep");

    do_op(4, 64'd3, 64'd5, "w4_3x5");
    do_op(4, 64'd15, 64'd15, "w4_15x15");
    do_op(4, 64'd0, 64'd9, "w4_0x9");
    for (int i = 0; i < 8; i++) begin
      ra = 64'($urandom_range(0, 15));
      rb = 64'($urandom_range(0, 15));
      do_op(4, ra, rb, "w4_rand");
    end

    // Second start two cycles into RUN must be dropped, not queued.
    @(negedge clk);
    set_in(4, 1'b1, 64'd6, 64'd4);
    @(posedge clk);
    @(negedge clk);
    set_in(4, 1'b0, 64'd6, 64'd4);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    set_in(4, 1'b1, 64'd7, 64'd7);
    @(posedge clk);
    @(negedge clk);
    set_in(4, 1'b0, 64'd0, 64'd0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (if4.done) begin
        pulses++;
        check("ign_product", 64'(if4.product), model(4, 64'd6, 64'd4));
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("ign_pulses", 64'(pulses), 64'd1);
    check("ign_idle", 64'(if4.busy), 64'd0);

    // Reset mid-RUN, between clock edges.
    do_op(8, 64'd123, 64'd45, "w8_pre");
    @(negedge clk);
    set_in(8, 1'b1, 64'd77, 64'd99);
    @(posedge clk);
    @(negedge clk);
    set_in(8, 1'b0, 64'd0, 64'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 64'(if8.busy), 64'd0);
    check("midrst_done", 64'(if8.done), 64'd0);
    check("midrst_prod", 64'(if8.product), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (if8.done) dn++;
    end
    check("midrst_no_done", 64'(dn), 64'd0);
    do_op(8, 64'd200, 64'd100, "w8_200x100");
    for (int i = 0; i < 6; i++) begin
      ra = 64'($urandom_range(0, 255));
      rb = 64'($urandom_range(0, 255));
      do_op(8, ra, rb, "w8_rand");
    end

    // start held high: back-to-back operations every WIDTH+2 edges.
    for (int i = 0; i < 3; i++) begin
      ha[i] = 64'($urandom_range(0, 15));
      hb[i] = 64'($urandom_range(0, 15));
    end
    @(negedge clk);
    set_in(4, 1'b1, ha[0], hb[0]);
    pulses = 0;
    last = 0;
    for (int c = 0; c < 40 && pulses < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (if4.done) begin
        check("held_product", 64'(if4.product), model(4, ha[pulses], hb[pulses]));
        if (pulses > 0) check("held_gap", 64'(c - last), 64'd6);
        last = c;
        pulses++;
        if (pulses < 3) set_in(4, 1'b1, ha[pulses], hb[pulses]);
      end else if (pulses > 0) begin
        check("held_hold", 64'(if4.product), model(4, ha[pulses-1], hb[pulses-1]));
      end
    end
    set_in(4, 1'b0, 64'd0, 64'd0);
    check("held_pulses", 64'(pulses), 64'd3);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);

`ifdef SEQ_MUL_SIGNED_EN
    do_op(4, 64'h8, 64'h8, "s_m8xm8");
    check("s_m8xm8_const", 64'(if4.product), 64'h40);
    do_op(4, 64'hD, 64'h5, "s_m3x5");
    check("s_m3x5_const", 64'(if4.product), 64'hF1);
    do_op(4, 64'h7, 64'hF, "s_7xm1");
    check("s_7xm1_const", 64'(if4.product), 64'hF9);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
